// File: rtl/hdmi_packet_pkg.sv
// Shared constants, types and the InfoFrame checksum helper for the HDMI data-island packet path.
package hdmi_packet_pkg;

    localparam int unsigned PACKET_BEATS     = 32;
    localparam int unsigned HEADER_DATA_BITS = 24;
    localparam int unsigned SUB_DATA_BITS    = 56;
    localparam logic [7:0]  BCH_POLY         = 8'h83;

    typedef logic [55:0] subpacket_t;
    typedef logic [23:0] header_t;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    // PB0 value that makes HB0..HB2 + PB0..PB27 sum to zero modulo 256.
    function automatic logic [7:0] infoframe_checksum(input header_t hdr, input logic [3:0][55:0] sub);
        logic [7:0] sum;
        sum = hdr[7:0] + hdr[15:8] + hdr[23:16];
        for (int unsigned n = 1; n < 28; n++) begin
            sum = sum + sub[n / 7][8 * (n % 7) +: 8];
        end
        return 8'd0 - sum;
    endfunction

endpackage

// File: rtl/bch_ecc_step.sv
// Combinational BCH(1+x^6+x^7+x^8) update over STEPS data bits, data[0] consumed first.
module bch_ecc_step
    import hdmi_packet_pkg::*;
#(
    parameter int unsigned STEPS = 1
) (
    input  logic [7:0]       ecc_in,
    input  logic [STEPS-1:0] data,
    output logic [7:0]       ecc_out
);

    always_comb begin
        ecc_out = ecc_in;
        for (int unsigned i = 0; i < STEPS; i++) begin
            ecc_out = (ecc_out[0] ^ data[i]) ? ((ecc_out >> 1) ^ BCH_POLY) : (ecc_out >> 1);
        end
    end

endmodule

// File: rtl/data_island_packet_assembler.sv
// Serialises one HDMI data-island packet (header + 4 subpackets + BCH ECC) into 32 beats of 9 bits.
// Optional feature: DATA_ISLAND_INFOFRAME_CHECKSUM_EN replaces PB0 with the InfoFrame checksum when HB0[7]=1.
module data_island_packet_assembler
    import hdmi_packet_pkg::*;
#(
    parameter int unsigned ZERO_WHEN_IDLE = 1
) (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             start,
    input  logic [23:0]      header,
    input  logic [3:0][55:0] sub,
    output logic [8:0]       packet_data,
    output logic             valid,
    output logic [4:0]       beat,
    output logic             last,
    output logic             overrun
);

    localparam logic [4:0] LAST_BEAT    = 5'(PACKET_BEATS - 1);
    localparam logic [4:0] HDR_ECC_BEAT = 5'(HEADER_DATA_BITS);
    localparam logic [4:0] SUB_ECC_BEAT = 5'(SUB_DATA_BITS / 2);

    state_t           state, state_n;
    header_t          hdr_q, hdr_n, src_hdr;
    logic [3:0][55:0] sub_q, sub_n, sub_in, src_sub;
    logic [7:0]       ecc_h, ecc_h_n, ecc_h_cur, ecc_h_step;
    logic [3:0][7:0]  ecc_s, ecc_s_n, ecc_s_cur, ecc_s_step;
    logic [4:0]       nb, beat_n;
    logic [3:0]       even_bits, odd_bits;
    logic [8:0]       data_n;
    logic             load, advance, hdr_bit, valid_n, last_n, overrun_n;

    always_comb begin
        sub_in = sub;
`ifdef DATA_ISLAND_INFOFRAME_CHECKSUM_EN
        if (header[7]) sub_in[0][7:0] = infoframe_checksum(header, sub);
`endif
    end

    // Registered outputs carry the beat being entered, so a load computes beat 0
    // straight from the inputs with zeroed ECC rather than from the latches.
    always_comb begin
        load      = start && (state == IDLE || beat == LAST_BEAT);
        advance   = (state == SEND) && (beat != LAST_BEAT);
        nb        = load ? 5'd0 : beat + 5'd1;
        src_hdr   = load ? header : hdr_q;
        src_sub   = load ? sub_in : sub_q;
        ecc_h_cur = load ? '0 : ecc_h;
        ecc_s_cur = load ? '0 : ecc_s;
        hdr_bit   = (nb < HDR_ECC_BEAT) ? src_hdr[nb] : 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            even_bits[k] = (nb < SUB_ECC_BEAT) ? src_sub[k][{nb, 1'b0}] : 1'b0;
            odd_bits[k]  = (nb < SUB_ECC_BEAT) ? src_sub[k][{nb, 1'b1}] : 1'b0;
        end
    end

    bch_ecc_step #(.STEPS(1)) u_hdr_ecc (
        .ecc_in  (ecc_h_cur),
        .data    (hdr_bit),
        .ecc_out (ecc_h_step)
    );

    for (genvar k = 0; k < 4; k++) begin : g_sub_ecc
        bch_ecc_step #(.STEPS(2)) u_sub_ecc (
            .ecc_in  (ecc_s_cur[k]),
            .data    ({odd_bits[k], even_bits[k]}),
            .ecc_out (ecc_s_step[k])
        );
    end

    always_comb begin
        state_n   = state;
        hdr_n     = hdr_q;
        sub_n     = sub_q;
        ecc_h_n   = ecc_h;
        ecc_s_n   = ecc_s;
        beat_n    = '0;
        valid_n   = 1'b0;
        last_n    = 1'b0;
        data_n    = (ZERO_WHEN_IDLE != 0) ? '0 : packet_data;
        overrun_n = overrun || (start && advance);
        if (load || advance) begin
            state_n = SEND;
            beat_n  = nb;
            valid_n = 1'b1;
            last_n  = (nb == LAST_BEAT);
            if (load) begin
                hdr_n = header;
                sub_n = sub_in;
            end
            data_n[0] = (nb < HDR_ECC_BEAT) ? hdr_bit : ecc_h_cur[0];
            ecc_h_n   = (nb < HDR_ECC_BEAT) ? ecc_h_step : (ecc_h_cur >> 1);
            for (int unsigned k = 0; k < 4; k++) begin
                data_n[1 + k] = (nb < SUB_ECC_BEAT) ? even_bits[k] : ecc_s_cur[k][0];
                data_n[5 + k] = (nb < SUB_ECC_BEAT) ? odd_bits[k]  : ecc_s_cur[k][1];
                ecc_s_n[k]    = (nb < SUB_ECC_BEAT) ? ecc_s_step[k] : (ecc_s_cur[k] >> 2);
            end
        end else begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            hdr_q       <= '0;
            sub_q       <= '0;
            ecc_h       <= '0;
            ecc_s       <= '0;
            packet_data <= '0;
            valid       <= 1'b0;
            beat        <= '0;
            last        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_n;
            hdr_q       <= hdr_n;
            sub_q       <= sub_n;
            ecc_h       <= ecc_h_n;
            ecc_s       <= ecc_s_n;
            packet_data <= data_n;
            valid       <= valid_n;
            beat        <= beat_n;
            last        <= last_n;
            overrun     <= overrun_n;
        end
    end

endmodule

// File: tb/tb_data_island_packet_assembler.sv
// Self-checking bench: queue-of-beats packet model compared every cycle, plus directed literal checks.
module tb_data_island_packet_assembler;

    logic             clk_pixel = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [23:0]      header = '0;
    logic [3:0][55:0] sub = '0;
    logic [8:0]       packet_data;
    logic             valid;
    logic [4:0]       beat;
    logic             last;
    logic             overrun;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;

    logic [13:0] exp_q[$];
    logic [13:0] exp_e;
    logic        exp_valid = 1'b0;
    logic        exp_last = 1'b0;
    logic        exp_ovr = 1'b0;
    logic [4:0]  exp_beat = '0;
    logic [8:0]  exp_data = '0;
    logic [8:0]  cap[32];

    always #5 clk_pixel = ~clk_pixel;

    data_island_packet_assembler #(.ZERO_WHEN_IDLE(1)) dut (
        .clk_pixel   (clk_pixel),
        .reset       (reset),
        .start       (start),
        .header      (header),
        .sub         (sub),
        .packet_data (packet_data),
        .valid       (valid),
        .beat        (beat),
        .last        (last),
        .overrun     (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] bch(input logic [63:0] bits, input int n);
        logic [7:0] e;
        logic       fb;
        e = 8'h00;
        for (int i = 0; i < n; i++) begin
            fb = e[0] ^ bits[i];
            e  = e >> 1;
            if (fb) e = e ^ 8'h83;
        end
        return e;
    endfunction

    function automatic logic [7:0] cksum(input logic [23:0] h, input logic [3:0][55:0] s);
        int total;
        total = int'(h[7:0]) + int'(h[15:8]) + int'(h[23:16]);
        for (int n = 1; n <= 27; n++) total += int'(s[n / 7][8 * (n % 7) +: 8]);
        return 8'((256 - (total % 256)) % 256);
    endfunction

    // Build the full 32-beat image of one packet and append it to the expected stream.
    task automatic push_packet(input logic [23:0] h, input logic [3:0][55:0] s_in);
        logic [3:0][55:0] s;
        logic [31:0]      hb;
        logic [3:0][63:0] sb;
        logic [8:0]       d;
        s = s_in;
`ifdef DATA_ISLAND_INFOFRAME_CHECKSUM_EN
        if (h[7]) s[0][7:0] = cksum(h, s_in);
`endif
        hb = {bch({40'b0, h}, 24), h};
        for (int k = 0; k < 4; k++) sb[k] = {bch({8'b0, s[k]}, 56), s[k]};
        for (int n = 0; n < 32; n++) begin
            d[0] = hb[n];
            for (int k = 0; k < 4; k++) begin
                d[1 + k] = sb[k][2 * n];
                d[5 + k] = sb[k][2 * n + 1];
            end
            exp_q.push_back({5'(n), d});
        end
    endtask

    always @(posedge clk_pixel) begin
        if (reset) begin
            exp_q.delete();
            exp_ovr = 1'b0;
        end else if (start) begin
            if (exp_q.size() == 0) push_packet(header, sub);
            else exp_ovr = 1'b1;
        end
        if (!reset && exp_q.size() > 0) begin
            exp_e     = exp_q.pop_front();
            exp_valid = 1'b1;
            exp_beat  = exp_e[13:9];
            exp_data  = exp_e[8:0];
            exp_last  = (exp_e[13:9] == 5'd31);
        end else begin
            exp_valid = 1'b0;
            exp_beat  = '0;
            exp_data  = '0;
            exp_last  = 1'b0;
        end
    end

    always @(negedge clk_pixel) begin
        if (valid === 1'b1) valid_cnt++;
        if (reset) begin
            check("rst_valid", 32'(valid), 32'h0);
            check("rst_data", 32'(packet_data), 32'h0);
            check("rst_beat", 32'(beat), 32'h0);
            check("rst_overrun", 32'(overrun), 32'h0);
        end else begin
            check("valid", 32'(valid), 32'(exp_valid));
            check("beat", 32'(beat), 32'(exp_beat));
            check("last", 32'(last), 32'(exp_last));
            check("packet_data", 32'(packet_data), 32'(exp_data));
            check("overrun", 32'(overrun), 32'(exp_ovr));
        end
    end

    task automatic run_capture(input logic [23:0] h, input logic [3:0][55:0] s);
        @(posedge clk_pixel); #1;
        start = 1'b1; header = h; sub = s;
        @(posedge clk_pixel); #1;
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk_pixel);
            cap[i] = packet_data;
        end
    endtask

    initial begin
        logic [3:0][55:0] s;
        logic [8:0]       acc;
        logic [7:0]       byte_v;
        logic [63:0]      r64;

        repeat (2) @(posedge clk_pixel);
        #1 reset = 1'b0;

        // Null packet
        valid_cnt = 0;
        run_capture(24'h0, '0);
        acc = '0;
        for (int i = 0; i < 32; i++) acc |= cap[i];
        check("null_all_zero", 32'(acc), 32'h0);
        repeat (2) @(negedge clk_pixel);
        check("null_valid_cycles", 32'(valid_cnt), 32'd32);

        // Header walk: ECC of header 24'h000001 is 8'h4A
        run_capture(24'h000001, '0);
        check("hdr_beat0", 32'(cap[0]), 32'h001);
        byte_v = '0;
        for (int i = 0; i < 8; i++) byte_v[i] = cap[24 + i][0];
        check("hdr_ecc", 32'(byte_v), 32'h4A);
        acc = '0;
        for (int i = 0; i < 32; i++) acc |= cap[i] & 9'h1FE;
        check("hdr_sub_lanes_zero", 32'(acc), 32'h0);

        // Subpacket 2 lane mapping
        s = '0;
        s[2] = 56'h1;
        run_capture(24'h0, s);
        check("sub2_beat0", 32'(cap[0]), 32'h008);
        acc = '0;
        for (int i = 0; i < 32; i++) acc |= cap[i] & ~9'h088;
        check("sub2_other_lanes", 32'(acc), 32'h0);

        // Back-to-back packets
        @(posedge clk_pixel); #1;
        valid_cnt = 0;
        start = 1'b1; header = 24'h00A5A5; r64 = {$urandom, $urandom}; sub[1] = r64[55:0];
        @(posedge clk_pixel); #1;
        start = 1'b0;
        repeat (31) @(posedge clk_pixel);
        #1 start = 1'b1; header = 24'h5A0F33;
        @(posedge clk_pixel); #1;
        start = 1'b0;
        check("b2b_wrap_beat", 32'(beat), 32'h0);
        check("b2b_wrap_valid", 32'(valid), 32'h1);
        repeat (33) @(posedge clk_pixel);
        @(negedge clk_pixel);
        check("b2b_valid_cycles", 32'(valid_cnt), 32'd64);
        check("b2b_no_overrun", 32'(overrun), 32'h0);

        // Overrun then reset mid-packet
        @(posedge clk_pixel); #1;
        start = 1'b1; header = 24'h123456; sub = '0;
        @(posedge clk_pixel); #1;
        start = 1'b0;
        repeat (10) @(posedge clk_pixel);
        #1 start = 1'b1; header = 24'hFFFFFF;
        @(posedge clk_pixel); #1;
        start = 1'b0;
        check("ovr_set", 32'(overrun), 32'h1);
        check("ovr_beat_continues", 32'(beat), 32'd11);
        repeat (4) @(posedge clk_pixel);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_valid", 32'(valid), 32'h0);
        check("rst_mid_beat", 32'(beat), 32'h0);
        check("rst_mid_overrun", 32'(overrun), 32'h0);
        @(posedge clk_pixel); #1 reset = 1'b0;

        // InfoFrame checksum packet
        s = '0;
        s[0][15:8]  = 8'h5c;
        s[0][23:16] = 8'h02;
        s[1][7:0]   = 8'hb5;
        run_capture(24'h1a0187, s);
        byte_v = '0;
        for (int n = 0; n < 4; n++) begin
            byte_v[2 * n]     = cap[n][1];
            byte_v[2 * n + 1] = cap[n][5];
        end
`ifdef DATA_ISLAND_INFOFRAME_CHECKSUM_EN
        check("pb0_checksum", 32'(byte_v), 32'h4B);
`else
        check("pb0_checksum", 32'(byte_v), 32'h00);
`endif

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk_pixel); #1;
            header = 24'($urandom);
            for (int k = 0; k < 4; k++) begin
                r64 = {$urandom, $urandom};
                sub[k] = r64[55:0];
            end
            if (exp_valid && exp_beat == 5'd31) start = ($urandom_range(0, 1) == 1);
            else start = ($urandom_range(0, 11) == 0);
        end
        @(posedge clk_pixel); #1 start = 1'b0;
        repeat (40) @(posedge clk_pixel);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
